rupt_priority_arb: RTL and testbench
====================================

// Module: rupt_priority_arb
// PURPOSE
//  Parametrised interrupt ("rupt") priority arbiter for the AGC core.
//  - Latches up to NCHAN rupt request pulses (T6RPT, KYRPT1, UPRUPT, DNRPTA, RADRPT, HNDRPT, ...).
//  - Offers a rupt to the sequencer at instruction boundaries and grants the highest-priority one.
//  - Generates the rupt vector address and tracks the in-service state through to RESUME.
//  - Generalises the fixed-width rupt priority logic to any channel count, base address and stride.
// PARAMETERS
//  NCHAN       10       number of rupt channels; channel 0 has the highest priority
//  AW          12       width of the rupt vector address
//  VEC_BASE    'o4000   vector address of channel 0
//  VEC_STRIDE  4        address step between consecutive channel vectors
//  LOCK_CYC    'd5000   service cycles before the RUPT LOCK alarm (RUPT_LOCK_EN only)
// PORTS
//  CLOCK    in   1      system clock; all state changes on the rising edge
//  rst      in   1      asynchronous reset, active-high
//  GOJAM    in   1      synchronous restart; same effect as rst at the next edge
//  RQST     in   NCHAN  request pulses; a 1-cycle high sets the pending bit
//  INHINT   in   1      interrupt inhibit; masks the offer, latching continues
//  INOVF    in   1      overflow in accumulator; masks the offer like INHINT
//  ACCEPT   in   1      sequencer at instruction boundary and takes the offered rupt
//  RESUME   in   1      end-of-ISR pulse
//  RUPTOR   out  1      rupt offered: state IDLE & |PEND & !INHINT & !INOVF
//  RPTVLD   out  1      1-cycle grant strobe; RPTADR/CHAN_ID valid this cycle
//  RPTADR   out  AW     VEC_BASE + CHAN_ID*VEC_STRIDE, truncated to AW bits
//  CHAN_ID  out  clog2(NCHAN)  granted channel, held through SERVICE
//  ACTIVE   out  1      high in GRANT and SERVICE
//  PEND     out  NCHAN  pending request bits
//  RLOCK    out  1      RUPT LOCK alarm, sticky
// BEHAVIOUR
//  Reset (rst or GOJAM): every output is 0; state is IDLE; PEND, the lock counter and RLOCK are cleared.
//  PEND[i] is set on RQST[i]=1 in any state.
//  PEND[i] is cleared only by the grant of channel i.
//  If a set and a grant-clear of the same channel fall in one cycle, the set wins (bit stays 1).
//  RUPTOR is combinational from registered state and the INHINT/INOVF inputs.
//  FSM (registered):
//   IDLE    -> GRANT when ACCEPT & RUPTOR. Latch CHAN_ID = lowest index with PEND=1 and
//              clear that PEND bit. ACCEPT while RUPTOR=0 is ignored.
//   GRANT   -> SERVICE unconditionally. RPTVLD=1 for exactly this cycle, so the grant lands
//              1 cycle after ACCEPT. RPTADR is registered and valid while RPTVLD=1.
//   SERVICE -> IDLE on RESUME. RUPTOR=0 throughout, so there is no nesting.
//              Requests arriving in SERVICE stay pending.
//  RESUME outside SERVICE is ignored.
//  RESUME on the cycle SERVICE is entered is ignored; it must arrive in SERVICE.
//  After RESUME the state is IDLE at the next edge. RUPTOR can then assert the same cycle
//  if PEND is non-zero, giving back-to-back service with one IDLE cycle minimum.
//  INHINT/INOVF rising while in IDLE does not cancel anything; only the offer is masked.
//  Asynchronous rst mid-SERVICE: immediate return to IDLE. Pending requests are lost.
//  RPTADR arithmetic is modulo 2^AW. Channel indices >= NCHAN never occur.
// CONFIGURATION
//  RUPT_LOCK_EN defined:
//   - A counter of width clog2(LOCK_CYC+1) increments each cycle in GRANT/SERVICE.
//   - It clears in IDLE.
//   - When the count reaches LOCK_CYC, RLOCK sets to 1 and stays 1 until rst/GOJAM.
//  RUPT_LOCK_EN undefined: no counter is built and RLOCK is tied to 0.
// TESTING
//  1. rst pulse with RQST=all ones applied during rst -> after release PEND=0, RUPTOR=0,
//     all outputs 0.
//  2. RQST[3] and RQST[7] pulsed together, then ACCEPT -> next cycle RPTVLD=1, CHAN_ID=3,
//     RPTADR='o4014, PEND[7] still 1.
//  3. INHINT=1 with PEND[0]=1 -> RUPTOR=0 and ACCEPT ignored.
//     Drop INHINT -> RUPTOR=1 the same cycle.
//  4. In SERVICE pulse RQST[1] -> RUPTOR stays 0. RESUME -> IDLE with RUPTOR=1.
//     ACCEPT -> CHAN_ID=1, RPTADR='o4004.
//  5. RQST[2] pulsed on the same cycle as the grant-clear of channel 2 -> PEND[2]=1 afterwards.
//  6. RUPT_LOCK_EN with LOCK_CYC=8: grant, then hold off RESUME -> RLOCK=1 on the 8th ACTIVE cycle.
//     RLOCK stays 1 after RESUME and clears on GOJAM.

Source files
------------

// File: rtl/rupt_priority_arb.sv
// Interrupt (rupt) priority arbiter: latches request pulses, offers the lowest pending channel at
// instruction boundaries, strobes its vector address and tracks service until RESUME. Macro RUPT_LOCK_EN adds the RUPT LOCK alarm.
module rupt_priority_arb #(
  parameter int NCHAN      = 10,
  parameter int AW         = 12,
  parameter int VEC_BASE   = 'o4000,
  parameter int VEC_STRIDE = 4,
  parameter int LOCK_CYC   = 'd5000,
  localparam int CW        = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic             GOJAM,
  input  logic [NCHAN-1:0] RQST,
  input  logic             INHINT,
  input  logic             INOVF,
  input  logic             ACCEPT,
  input  logic             RESUME,
  output logic             RUPTOR,
  output logic             RPTVLD,
  output logic [AW-1:0]    RPTADR,
  output logic [CW-1:0]    CHAN_ID,
  output logic             ACTIVE,
  output logic [NCHAN-1:0] PEND,
  output logic             RLOCK
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_SERVICE} state_e;

  state_e           state_q, state_d;
  logic [NCHAN-1:0] pend_q, pend_d;
  logic [CW-1:0]    chan_q, chan_d, pick;
  logic [AW-1:0]    adr_q, adr_d;
  logic             offer, grant;

  // Lowest pending index wins: scanning downward lets the last hit stand.
  always_comb begin
    // NOTE: every variable written here gets a value first, so no latch can be inferred.
    pick = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (pend_q[i]) pick = CW'(i);
    end
  end

  assign offer = (state_q == ST_IDLE) && (|pend_q) && !INHINT && !INOVF;
  assign grant = offer && ACCEPT;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant) state_d = ST_GRANT;
      ST_GRANT:   state_d = ST_SERVICE;
      ST_SERVICE: if (RESUME) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (GOJAM) state_d = ST_IDLE;
  end

  // A new request is OR-ed in after the grant-clear, so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    chan_d = chan_q;
    adr_d  = adr_q;
    if (grant) begin
      pend_d[pick] = 1'b0;
      chan_d       = pick;
      adr_d        = AW'(VEC_BASE) + AW'(pick) * AW'(VEC_STRIDE);
    end
    pend_d = pend_d | RQST;
    if (GOJAM) begin
      pend_d = '0;
      chan_d = '0;
      adr_d  = '0;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      chan_q  <= '0;
      adr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      pend_q  <= pend_d;
      chan_q  <= chan_d;
      adr_q   <= adr_d;
    end
  end

  always_comb begin
    RUPTOR = offer;
    RPTVLD = (state_q == ST_GRANT);
    ACTIVE = (state_q != ST_IDLE);
  end

  assign RPTADR  = adr_q;
  assign CHAN_ID = chan_q;
  assign PEND    = pend_q;

`ifdef RUPT_LOCK_EN
  localparam int LW = $clog2(LOCK_CYC + 1);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rlock_q, rlock_d;

  // Counts GRANT/SERVICE cycles, saturating at LOCK_CYC; any IDLE cycle restarts it.
  always_comb begin
    lock_cnt_d = '0;
    rlock_d    = rlock_q;
    if (state_q != ST_IDLE) begin
      lock_cnt_d = (lock_cnt_q == LW'(LOCK_CYC)) ? lock_cnt_q : lock_cnt_q + 1'b1;
    end
    if (lock_cnt_d == LW'(LOCK_CYC)) rlock_d = 1'b1;
    if (GOJAM) begin
      lock_cnt_d = '0;
      rlock_d    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= '0;
      rlock_q    <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      rlock_q    <= rlock_d;
    end
  end

  assign RLOCK = rlock_q;
`else
  assign RLOCK = 1'b0;
`endif

endmodule

// File: tb/tb_rupt_priority_arb.sv
// Self-checking bench for rupt_priority_arb: directed scenarios plus randomized traffic compared
// against a behavioural model of pending set, service phase and lock timing.
module tb_rupt_priority_arb;

  localparam int NCHAN      = 10;
  localparam int AW         = 12;
  localparam int VEC_BASE   = 'o4000;
  localparam int VEC_STRIDE = 4;
  localparam int LOCK_CYC   = 8;
  localparam int CW         = $clog2(NCHAN);

  logic             CLOCK = 1'b0;
  logic             rst = 1'b1;
  logic             GOJAM = 1'b0;
  logic [NCHAN-1:0] RQST = '0;
  logic             INHINT = 1'b0;
  logic             INOVF = 1'b0;
  logic             ACCEPT = 1'b0;
  logic             RESUME = 1'b0;
  logic             RUPTOR, RPTVLD, ACTIVE, RLOCK;
  logic [AW-1:0]    RPTADR;
  logic [CW-1:0]    CHAN_ID;
  logic [NCHAN-1:0] PEND;

  int errors = 0;
  int checks = 0;

  rupt_priority_arb #(
    .NCHAN(NCHAN), .AW(AW), .VEC_BASE(VEC_BASE), .VEC_STRIDE(VEC_STRIDE), .LOCK_CYC(LOCK_CYC)
  ) dut (
    .CLOCK(CLOCK), .rst(rst), .GOJAM(GOJAM), .RQST(RQST), .INHINT(INHINT), .INOVF(INOVF),
    .ACCEPT(ACCEPT), .RESUME(RESUME), .RUPTOR(RUPTOR), .RPTVLD(RPTVLD), .RPTADR(RPTADR),
    .CHAN_ID(CHAN_ID), .ACTIVE(ACTIVE), .PEND(PEND), .RLOCK(RLOCK)
  );

  always #5 CLOCK = ~CLOCK;

  // Behavioural model: pending flags, "busy" (granted, not yet resumed), grant strobe, lock timer.
  bit m_pend[NCHAN];
  bit m_busy, m_strobe, m_rlock;
  int m_chan, m_addr, m_act;

  function automatic void m_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_busy = 0; m_strobe = 0; m_rlock = 0;
    m_chan = 0; m_addr = 0; m_act = 0;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < NCHAN; i++) if (m_pend[i]) return i;
    return -1;
  endfunction

  function automatic bit m_offer();
    return !m_busy && (m_lowest() >= 0) && !INHINT && !INOVF;
  endfunction

  function automatic logic [NCHAN-1:0] m_pend_vec();
    logic [NCHAN-1:0] v;
    for (int i = 0; i < NCHAN; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit m_rlock_exp();
`ifdef RUPT_LOCK_EN
    return m_rlock;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void m_edge();
    bit offer   = m_offer();
    int lo      = m_lowest();
    bit was_act = m_busy;
    if (GOJAM) begin
      m_reset();
      return;
    end
    if (!m_busy) begin
      if (ACCEPT && offer) begin
        m_pend[lo] = 1'b0;
        m_chan     = lo;
        m_addr     = (VEC_BASE + lo * VEC_STRIDE) % (1 << AW);
        m_busy     = 1;
        m_strobe   = 1;
      end
    end else if (m_strobe) begin
      m_strobe = 0;
    end else if (RESUME) begin
      m_busy = 0;
    end
    for (int i = 0; i < NCHAN; i++) if (RQST[i]) m_pend[i] = 1'b1;
    m_act = was_act ? m_act + 1 : 0;
    if (m_act >= LOCK_CYC) m_rlock = 1;
  endfunction

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic apply(input logic [NCHAN-1:0] rq, input logic acc, input logic res,
                       input logic inh, input logic ovf, input logic gj);
    RQST = rq; ACCEPT = acc; RESUME = res; INHINT = inh; INOVF = ovf; GOJAM = gj;
    #1;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    m_edge();
    @(negedge CLOCK);
  endtask

  task automatic serve_one();
    apply('0, 1, 0, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0); tick();
    apply('0, 0, 1, 0, 0, 0); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_reset();
    apply('1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    apply('0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checks++; if (PEND !== '0) begin errors++; $display("FAIL reset_pend: got %h want 0", PEND); end
    checks++; if (RUPTOR !== 1'b0) begin errors++; $display("FAIL reset_ruptor: got %b want 0", RUPTOR); end
    checks++; if (RPTVLD !== 1'b0) begin errors++; $display("FAIL reset_rptvld: got %b want 0", RPTVLD); end
    checks++; if (RPTADR !== '0) begin errors++; $display("FAIL reset_rptadr: got %o want 0", RPTADR); end
    checks++; if (CHAN_ID !== '0) begin errors++; $display("FAIL reset_chan: got %0d want 0", CHAN_ID); end
    checks++; if (ACTIVE !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", ACTIVE); end
    checks++; if (RLOCK !== 1'b0) begin errors++; $display("FAIL reset_rlock: got %b want 0", RLOCK); end
  endtask

  task automatic test_priority();
    apply(10'b00_1000_1000, 0, 0, 0, 0, 0); tick();
    apply('0, 1, 0, 0, 0, 0);
    checks++; if (RUPTOR !== 1'b1) begin errors++; $display("FAIL prio_offer: got %b want 1", RUPTOR); end
    tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (RPTVLD !== 1'b1) begin errors++; $display("FAIL prio_vld: got %b want 1", RPTVLD); end
    checks++; if (CHAN_ID !== 4'd3) begin errors++; $display("FAIL prio_chan: got %0d want 3", CHAN_ID); end
    checks++; if (RPTADR !== 12'o4014) begin errors++; $display("FAIL prio_adr: got %o want 4014", RPTADR); end
    checks++; if (PEND !== 10'b00_1000_0000) begin errors++; $display("FAIL prio_pend: got %b want 0010000000", PEND); end
    tick();
    checks++; if (RPTVLD !== 1'b0 || ACTIVE !== 1'b1 || CHAN_ID !== 4'd3) begin
      errors++; $display("FAIL prio_service: vld=%b active=%b chan=%0d want 0/1/3", RPTVLD, ACTIVE, CHAN_ID);
    end
    apply('0, 0, 1, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (ACTIVE !== 1'b0 || RUPTOR !== 1'b1) begin
      errors++; $display("FAIL prio_resume: active=%b ruptor=%b want 0/1", ACTIVE, RUPTOR);
    end
    apply('0, 1, 0, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (CHAN_ID !== 4'd7 || RPTADR !== 12'o4034) begin
      errors++; $display("FAIL prio_second: chan=%0d adr=%o want 7/4034", CHAN_ID, RPTADR);
    end
    tick();
    apply('0, 0, 1, 0, 0, 0); tick();
  endtask

  task automatic test_inhibit();
    apply(10'b1, 0, 0, 0, 0, 0); tick();
    apply('0, 1, 0, 1, 0, 0);
    checks++; if (RUPTOR !== 1'b0) begin errors++; $display("FAIL inh_mask: got %b want 0", RUPTOR); end
    tick();
    apply('0, 1, 0, 0, 1, 0);
    checks++; if (ACTIVE !== 1'b0 || PEND[0] !== 1'b1 || RUPTOR !== 1'b0) begin
      errors++; $display("FAIL inh_ignored: active=%b pend0=%b ruptor=%b want 0/1/0", ACTIVE, PEND[0], RUPTOR);
    end
    tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (ACTIVE !== 1'b0 || RUPTOR !== 1'b1) begin
      errors++; $display("FAIL inh_release: active=%b ruptor=%b want 0/1", ACTIVE, RUPTOR);
    end
    serve_one();
  endtask

  task automatic test_no_nesting();
    apply(10'b1_0000, 0, 0, 0, 0, 0); tick();
    apply('0, 1, 0, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0); tick();
    apply(10'b10, 0, 0, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (RUPTOR !== 1'b0 || PEND[1] !== 1'b1) begin
      errors++; $display("FAIL nest_blocked: ruptor=%b pend1=%b want 0/1", RUPTOR, PEND[1]);
    end
    apply('0, 0, 1, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (RUPTOR !== 1'b1) begin errors++; $display("FAIL nest_reoffer: got %b want 1", RUPTOR); end
    apply('0, 1, 0, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (RPTVLD !== 1'b1 || CHAN_ID !== 4'd1 || RPTADR !== 12'o4004) begin
      errors++; $display("FAIL nest_grant: vld=%b chan=%0d adr=%o want 1/1/4004", RPTVLD, CHAN_ID, RPTADR);
    end
    tick();
    apply('0, 0, 1, 0, 0, 0); tick();
  endtask

  task automatic test_set_wins();
    apply(10'b100, 0, 0, 0, 0, 0); tick();
    apply(10'b100, 1, 0, 0, 0, 0); tick();
    apply('0, 0, 1, 0, 0, 0);
    checks++; if (PEND[2] !== 1'b1 || CHAN_ID !== 4'd2) begin
      errors++; $display("FAIL setwins_pend: pend2=%b chan=%0d want 1/2", PEND[2], CHAN_ID);
    end
    tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (ACTIVE !== 1'b1) begin errors++; $display("FAIL resume_in_grant: active=%b want 1", ACTIVE); end
    apply('0, 0, 1, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (ACTIVE !== 1'b0 || RUPTOR !== 1'b1) begin
      errors++; $display("FAIL setwins_reoffer: active=%b ruptor=%b want 0/1", ACTIVE, RUPTOR);
    end
    serve_one();
  endtask

  task automatic test_restart();
    apply(10'b100_0000, 0, 0, 0, 0, 0); tick();
    apply('0, 1, 0, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0); tick();
    apply(10'b10_0000, 0, 0, 0, 0, 1); tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (PEND !== '0 || ACTIVE !== 1'b0 || CHAN_ID !== '0 || RPTADR !== '0) begin
      errors++; $display("FAIL gojam_clear: pend=%h active=%b chan=%0d adr=%o want all 0", PEND, ACTIVE, CHAN_ID, RPTADR);
    end
    apply(10'b1_0000_0000, 0, 0, 0, 0, 0); tick();
    apply('0, 1, 0, 0, 0, 0); tick();
    apply(10'b10_0000_0000, 0, 0, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    m_reset();
    #1;
    checks++; if (ACTIVE !== 1'b0 || PEND !== '0 || RUPTOR !== 1'b0) begin
      errors++; $display("FAIL async_rst: active=%b pend=%h ruptor=%b want 0/0/0", ACTIVE, PEND, RUPTOR);
    end
    rst = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic test_lock();
    bit exp;
    apply(10'b1, 0, 0, 0, 0, 0); tick();
    apply('0, 1, 0, 0, 0, 0); tick();
    for (int k = 1; k <= LOCK_CYC + 4; k++) begin
      apply('0, 0, 0, 0, 0, 0);
`ifdef RUPT_LOCK_EN
      exp = (k > LOCK_CYC);
`else
      exp = 1'b0;
`endif
      checks++; if (RLOCK !== exp) begin errors++; $display("FAIL lock_cycle%0d: got %b want %b", k, RLOCK, exp); end
      tick();
    end
    apply('0, 0, 1, 0, 0, 0); tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (RLOCK !== m_rlock_exp()) begin errors++; $display("FAIL lock_sticky: got %b want %b", RLOCK, m_rlock_exp()); end
    apply('0, 0, 0, 0, 0, 1); tick();
    apply('0, 0, 0, 0, 0, 0);
    checks++; if (RLOCK !== 1'b0) begin errors++; $display("FAIL lock_gojam: got %b want 0", RLOCK); end
  endtask

  task automatic test_random();
    logic [NCHAN-1:0] rq;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NCHAN; i++) rq[i] = ($urandom_range(0, 9) == 0);
      apply(rq, $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0);
      checks++; if (RUPTOR !== m_offer()) begin errors++; $display("FAIL rnd%0d_ruptor: got %b want %b", n, RUPTOR, m_offer()); end
      checks++; if (PEND !== m_pend_vec()) begin errors++; $display("FAIL rnd%0d_pend: got %b want %b", n, PEND, m_pend_vec()); end
      checks++; if (ACTIVE !== m_busy) begin errors++; $display("FAIL rnd%0d_active: got %b want %b", n, ACTIVE, m_busy); end
      checks++; if (RPTVLD !== m_strobe) begin errors++; $display("FAIL rnd%0d_vld: got %b want %b", n, RPTVLD, m_strobe); end
      checks++; if (CHAN_ID !== CW'(m_chan)) begin errors++; $display("FAIL rnd%0d_chan: got %0d want %0d", n, CHAN_ID, m_chan); end
      checks++; if (RPTADR !== AW'(m_addr)) begin errors++; $display("FAIL rnd%0d_adr: got %o want %o", n, RPTADR, m_addr); end
      checks++; if (RLOCK !== m_rlock_exp()) begin errors++; $display("FAIL rnd%0d_rlock: got %b want %b", n, RLOCK, m_rlock_exp()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_inhibit();
    test_no_nesting();
    test_set_wins();
    test_restart();
    test_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
